// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX slot to Pi bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package msx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // a0 phase select on the Pi bus
    localparam logic PHASE_ADDR = 1'b0;
    localparam logic PHASE_DATA = 1'b1;

    // rw direction on the Pi bus
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/msx_sync.sv
// N-stage, W-bit flop synchroniser for asynchronous inputs.
// Latency: N clk cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk, reset (sync active-high), d_i async input, q_o synchronised output.
module msx_sync #(
    parameter int              N       = 2,
    parameter int              W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stg_q [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                stg_q[i] <= RST_VAL;
            end
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q_o = stg_q[N-1];

endmodule

// File: rtl/msx_bus_sequencer.sv
// Turns one MSX slot cycle into an address phase then a data phase on the Pi bus.
// Latency: SYNC_STAGES+1 clk from strobe fall to mwait low; each phase waits for a rack rise.
// Backpressure: MSX held in WAIT until both phases are acked or a phase times out.
// Ports: MSX side (msltsl/mmreq/miorq/mrd/mwr strobes, maddr, mdata_in/out/oe, mwait),
//        Pi side (cs, a0, rw, rmirq, md_out/md_oe/md_in, rack), status (busy, timeout).
module msx_bus_sequencer
    import msx_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 1023,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RD_DEFAULT  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msltsl,
    input  logic        mmreq,
    input  logic        miorq,
    input  logic        mrd,
    input  logic        mwr,
    input  logic [15:0] maddr,
    input  logic [7:0]  mdata_in,
    output logic [7:0]  mdata_out,
    output logic        mdata_oe,
    output logic        mwait,
    output logic        cs,
    output logic        a0,
    output logic        rw,
    output logic        rmirq,
    output logic [15:0] md_out,
    output logic        md_oe,
    input  logic [15:0] md_in,
    input  logic        rack,
    output logic        busy,
    output logic        timeout
);

    localparam int         CNT_W   = 10;
    // Abort on the edge whose increment would make the count TIMEOUT_CYC, so the
    // timeout pulse appears exactly TIMEOUT_CYC cycles after the phase was entered.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // ---------------- synchronisers ----------------
    logic [4:0] strb_s;
    logic       s_msltsl, s_mmreq, s_miorq, s_mrd, s_mwr;
    logic       s_rack;

    msx_sync #(.N(SYNC_STAGES), .W(5), .RST_VAL(5'b11111)) u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .d_i   ({msltsl, mmreq, miorq, mrd, mwr}),
        .q_o   (strb_s)
    );

    msx_sync #(.N(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_sync_rack (
        .clk   (clk),
        .reset (reset),
        .d_i   (rack),
        .q_o   (s_rack)
    );

    assign {s_msltsl, s_mmreq, s_miorq, s_mrd, s_mwr} = strb_s;

    // Upper Pi data byte is never consumed.
    logic unused_md_hi;
    assign unused_md_hi = ^md_in[15:8];

    // ---------------- request decode ----------------
    logic one_strobe;
    logic mem_req;
    logic io_req;
    logic req_vld;

    assign one_strobe = s_mrd ^ s_mwr;
    assign mem_req    = !s_msltsl && !s_mmreq && one_strobe;
    assign io_req     = !s_miorq && one_strobe;
    // Simultaneous memory and I/O requests are ambiguous and never start a cycle.
    assign req_vld    = (mem_req || io_req) && !(!s_mmreq && !s_miorq);

    // ---------------- state and registered outputs ----------------
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               rack_prev_q;
    logic               rack_rise;
    logic               cnt_hit;
    logic [7:0]         wdata_q;

    logic               cs_q, a0_q, rw_q, rmirq_q, md_oe_q, mwait_q;
    logic               mdata_oe_q, busy_q, timeout_q;
    logic [15:0]        md_out_q;
    logic [7:0]         mdata_out_q;

    // Edge detect runs in every state, so a rack that rose during IDLE or
    // RELEASE is already "seen" and cannot pre-arm the next phase.
    assign rack_rise = s_rack && !rack_prev_q;
    assign cnt_hit   = (cnt_q == TO_LAST);
    assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rack_prev_q <= 1'b0;
            wdata_q     <= '0;
            cs_q        <= 1'b1;
            a0_q        <= PHASE_ADDR;
            rw_q        <= RW_READ;
            rmirq_q     <= 1'b0;
            md_out_q    <= '0;
            md_oe_q     <= 1'b0;
            mwait_q     <= 1'b1;
            mdata_oe_q  <= 1'b0;
            mdata_out_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            rack_prev_q <= s_rack;
            timeout_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        state_q  <= ADDR;
                        cnt_q    <= '0;
                        wdata_q  <= mdata_in;
                        // rw is high while the read strobe is the active one
                        rw_q     <= !s_mrd ? RW_READ : RW_WRITE;
                        rmirq_q  <= io_req;
                        cs_q     <= 1'b0;
                        a0_q     <= PHASE_ADDR;
                        md_out_q <= maddr;
                        md_oe_q  <= 1'b1;
                        mwait_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                ADDR: begin
                    if (rack_rise) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        a0_q    <= PHASE_DATA;
                        if (rw_q == RW_WRITE) begin
                            md_out_q <= {8'h00, wdata_q};
                            md_oe_q  <= 1'b1;
                        end else begin
                            md_oe_q  <= 1'b0;
                        end
                    end else if (cnt_hit) begin
                        state_q     <= RELEASE;
                        cnt_q       <= '0;
                        timeout_q   <= 1'b1;
                        cs_q        <= 1'b1;
                        a0_q        <= PHASE_ADDR;
                        md_oe_q     <= 1'b0;
                        mwait_q     <= 1'b1;
                        if (rw_q == RW_READ) begin
                            mdata_out_q <= RD_DEFAULT;
                            mdata_oe_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                DATA: begin
                    // An ack landing on the timeout edge wins over the abort.
                    if (rack_rise || cnt_hit) begin
                        state_q   <= RELEASE;
                        cnt_q     <= '0;
                        timeout_q <= !rack_rise;
                        cs_q      <= 1'b1;
                        a0_q      <= PHASE_ADDR;
                        md_oe_q   <= 1'b0;
                        mwait_q   <= 1'b1;
                        if (rw_q == RW_READ) begin
                            mdata_out_q <= rack_rise ? md_in[7:0] : RD_DEFAULT;
                            mdata_oe_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                RELEASE: begin
                    if (s_mrd && s_mwr) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        mdata_oe_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cs        = cs_q;
    assign a0        = a0_q;
    assign rw        = rw_q;
    assign rmirq     = rmirq_q;
    assign md_out    = md_out_q;
    assign md_oe     = md_oe_q;
    assign mwait     = mwait_q;
    assign mdata_oe  = mdata_oe_q;
    assign mdata_out = mdata_out_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_msx_bus_sequencer.sv
// Self-checking bench for msx_bus_sequencer with a phase scoreboard.
// Latency: n/a.
// Backpressure: Pi responder acks phases after a fixed delay or not at all.
module tb_msx_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        msltsl, mmreq, miorq, mrd, mwr;
    logic [15:0] maddr;
    logic [7:0]  mdata_in;
    logic [7:0]  mdata_out;
    logic        mdata_oe, mwait, cs, a0, rw, rmirq, md_oe;
    logic [15:0] md_out;
    logic [15:0] md_in;
    logic        rack;
    logic        busy, timeout;

    always #5 clk = ~clk;

    msx_bus_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .msltsl    (msltsl),
        .mmreq     (mmreq),
        .miorq     (miorq),
        .mrd       (mrd),
        .mwr       (mwr),
        .maddr     (maddr),
        .mdata_in  (mdata_in),
        .mdata_out (mdata_out),
        .mdata_oe  (mdata_oe),
        .mwait     (mwait),
        .cs        (cs),
        .a0        (a0),
        .rw        (rw),
        .rmirq     (rmirq),
        .md_out    (md_out),
        .md_oe     (md_oe),
        .md_in     (md_in),
        .rack      (rack),
        .busy      (busy),
        .timeout   (timeout)
    );

    typedef struct {
        logic        a0;
        logic [15:0] md;
        logic        oe;
        logic        rw;
        logic        io;
    } ph_t;

    ph_t        exp_q [$];
    logic [7:0] rd_q  [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic strobes_idle();
        msltsl = 1'b1; mmreq = 1'b1; miorq = 1'b1; mrd = 1'b1; mwr = 1'b1;
    endtask

    task automatic start_req(input bit is_io, input bit is_read,
                             input logic [15:0] addr, input logic [7:0] wdata);
        maddr    = addr;
        mdata_in = wdata;
        msltsl   = is_io;
        mmreq    = is_io;
        miorq    = !is_io;
        mrd      = !is_read;
        mwr      = is_read;
    endtask

    // Wait (bounded) for the sequencer to drop back to IDLE after strobes rise.
    task automatic finish_cycle(input string tag);
        int n;
        strobes_idle();
        n = 0;
        while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_busy_clr"}, busy, 1'b0);
        chk({tag, "_doe_clr"}, mdata_oe, 1'b0);
    endtask

    task automatic msx_cycle(input string tag, input bit is_io, input bit is_read,
                             input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdval, input bit pre_rack);
        ph_t p;
        int  lat;
        int  n;
        p.a0 = 1'b0; p.md = addr; p.oe = 1'b1; p.rw = is_read; p.io = is_io;
        exp_q.push_back(p);
        p.a0 = 1'b1; p.md = {8'h00, wdata}; p.oe = !is_read;
        exp_q.push_back(p);
        if (is_read) rd_q.push_back(rdval);
        md_in = {8'hA5, rdval};

        if (pre_rack) rack = 1'b1;
        @(negedge clk);
        start_req(is_io, is_read, addr, wdata);
        lat = 0;
        while (mwait !== 1'b0 && lat < 10) begin @(negedge clk); lat++; end
        chk({tag, "_wait_lat"}, lat, 3);

        if (pre_rack) begin
            repeat (8) @(negedge clk);
            chk({tag, "_prearm_hold"}, {cs, a0}, 2'b00);
            rack = 1'b0;
            repeat (4) @(negedge clk);
        end

        for (int ph = 0; ph < 2; ph++) begin
            repeat (5) @(negedge clk);
            p = exp_q.pop_front();
            chk({tag, "_a0"}, a0, p.a0);
            chk({tag, "_cs"}, cs, 1'b0);
            chk({tag, "_mwait"}, mwait, 1'b0);
            chk({tag, "_md_oe"}, md_oe, p.oe);
            chk({tag, "_rw"}, rw, p.rw);
            chk({tag, "_rmirq"}, rmirq, p.io);
            if (p.oe) chk({tag, "_md_out"}, md_out, p.md);
            rack = 1'b1;
            n = 0;
            while (a0 === p.a0 && cs === 1'b0 && n < 20) begin @(negedge clk); n++; end
            chk({tag, "_ack_adv"}, n < 20, 1'b1);
            rack = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk({tag, "_rel_mwait"}, mwait, 1'b1);
        chk({tag, "_rel_cs"}, cs, 1'b1);
        chk({tag, "_rel_md_oe"}, md_oe, 1'b0);
        chk({tag, "_rel_doe"}, mdata_oe, is_read);
        if (is_read) chk({tag, "_rdata"}, mdata_out, rd_q.pop_front());
        finish_cycle(tag);
    endtask

    task automatic invalid_req(input string tag, input logic sl, input logic mq,
                               input logic iq, input logic rd, input logic wr);
        logic saw_busy;
        logic saw_wait;
        saw_busy = 1'b0;
        saw_wait = 1'b0;
        @(negedge clk);
        msltsl = sl; mmreq = mq; miorq = iq; mrd = rd; mwr = wr;
        repeat (12) begin
            @(negedge clk);
            saw_busy |= busy;
            saw_wait |= !mwait;
        end
        chk({tag, "_busy"}, saw_busy, 1'b0);
        chk({tag, "_mwait"}, saw_wait, 1'b0);
        strobes_idle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ph_t p;
        int  n;
        int  k;

        reset = 1'b1;
        strobes_idle();
        maddr = '0; mdata_in = '0; md_in = '0; rack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cs, a0, rw, rmirq, md_oe, mwait, mdata_oe, busy, timeout}, 9'b101001000);
        chk("rst_md_out", md_out, 16'h0000);
        chk("rst_mdata_out", mdata_out, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Memory write and I/O read, Pi acks after 5 cycles
        msx_cycle("memwr", 1'b0, 1'b0, 16'h4000, 8'h5A, 8'h00, 1'b0);
        msx_cycle("iord",  1'b1, 1'b1, 16'h0098, 8'h00, 8'hC3, 1'b0);
        msx_cycle("iowr",  1'b1, 1'b0, 16'h00A8, 8'h81, 8'h00, 1'b0);

        // Read with no ack: address phase aborts on timeout
        p.a0 = 1'b0; p.md = 16'h8000; p.oe = 1'b1; p.rw = 1'b1; p.io = 1'b0;
        exp_q.push_back(p);
        md_in = 16'h0012;
        @(negedge clk);
        start_req(1'b0, 1'b1, 16'h8000, 8'h00);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("to_busy", busy, 1'b1);
        p = exp_q.pop_front();
        chk("to_md_out", md_out, p.md);
        chk("to_a0", a0, p.a0);
        k = 0;
        while (timeout !== 1'b1 && k < 1100) begin @(negedge clk); k++; end
        chk("to_cycles", k, 1023);
        chk("to_mwait", mwait, 1'b1);
        chk("to_rdata", mdata_out, 8'hFF);
        chk("to_doe", mdata_oe, 1'b1);
        chk("to_cs", cs, 1'b1);
        @(negedge clk);
        chk("to_pulse_w", timeout, 1'b0);
        finish_cycle("to");

        // Ambiguous requests never start a cycle
        invalid_req("inv_rdwr",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        invalid_req("inv_memio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the data phase drops the transaction
        @(negedge clk);
        start_req(1'b0, 1'b0, 16'h1234, 8'h77);
        n = 0;
        while (mwait !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        rack = 1'b1;
        n = 0;
        while (a0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("rstd_in_data", a0, 1'b1);
        rack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        strobes_idle();
        @(negedge clk);
        chk("rstd_outs", {cs, md_oe, mwait, busy}, 4'b1010);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        msx_cycle("rstd_fresh", 1'b0, 1'b1, 16'h5555, 8'h00, 8'h6E, 1'b0);

        // rack held high from IDLE must not advance ADDR
        msx_cycle("prearm", 1'b0, 1'b1, 16'h2345, 8'h00, 8'h3C, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
